// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues reads to instruction memory and presents one
// registered instruction (with its PC) to the control unit.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] NOP_INSTR = 16'h000F
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect_en,
  input  logic [7:0]  redirect_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [7:0]  instr_pc,
  output logic        dbg_state
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] fetch_pc;
  logic       capture;
  logic       consume;
  logic       pending;

  // Handshakes: a memory read completes on a posedge with imem_req && imem_ready;
  // an instruction is consumed on a posedge with instr_valid && !stall.
  always_comb begin
    imem_req   = rst_n && (state == RUN) && !redirect_en && (!instr_valid || !stall);
    capture    = imem_req && imem_ready;
    consume    = instr_valid && !stall;
    pending    = imem_req && !imem_ready;
    state_next = state;
    if (redirect_en) begin
      state_next = RUN;
    end else if ((state == RUN) && halt && !pending) begin
      state_next = HALTED;
    end
  end

  assign imem_addr = fetch_pc;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_pc    <= 8'h00;
      instr_valid <= 1'b0;
    end else if (redirect_en) begin
      // A redirect flushes the buffered instruction and drops any read data.
      fetch_pc    <= redirect_addr;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr       <= imem_rdata;
      instr_pc    <= fetch_pc;
      instr_valid <= 1'b1;
      fetch_pc    <= fetch_pc + 8'd1;
    end else if (consume) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset checks, a fixed vector table, directed corner
// sequences, then random traffic compared against a queue-based model.
module tb_fetch_unit;

  localparam logic [7:0]  RESET_PC  = 8'h00;
  localparam logic [15:0] NOP_INSTR = 16'h000F;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        halt;
  logic        redirect_en;
  logic [7:0]  redirect_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .halt(halt),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .instr(instr),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory contents as a function of address, a queue holding
  // the (at most one) undelivered instruction, the next fetch address and a
  // halted flag.
  logic [23:0] exp_q[$];
  logic [7:0]  m_pc;
  logic        m_halted;
  logic        act_req;
  logic [7:0]  act_addr;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver task: one clock cycle with the given inputs, checked against the model
  task automatic step(input logic s, input logic h, input logic r, input logic [7:0] ra,
                      input logic rdy, input logic rn);
    logic exp_req;
    logic consumed;
    logic fetched;
    @(negedge clk);
    rst_n         = rn;
    stall         = s;
    halt          = h;
    redirect_en   = r;
    redirect_addr = ra;
    imem_ready    = rdy;
    imem_rdata    = mem_word(m_pc);
    #1;
    exp_req  = rn && !m_halted && !r && (exp_q.size() == 0 || !s);
    act_req  = imem_req;
    act_addr = imem_addr;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (rn) chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
    @(posedge clk);
    if (!rn) begin
      exp_q.delete();
      m_pc     = RESET_PC;
      m_halted = 1'b0;
    end else if (r) begin
      exp_q.delete();
      m_pc     = ra;
      m_halted = 1'b0;
    end else begin
      consumed = (exp_q.size() != 0) && !s;
      fetched  = exp_req && rdy;
      if (consumed) void'(exp_q.pop_front());
      if (fetched) begin
        exp_q.push_back({mem_word(m_pc), m_pc});
        m_pc = m_pc + 8'd1;
      end
      if (!m_halted && h && !(exp_req && !rdy)) m_halted = 1'b1;
    end
    #1;
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
    chk("dbg_state", {31'd0, dbg_state}, {31'd0, m_halted});
    if (exp_q.size() != 0) begin
      chk("instr", {16'd0, instr}, {16'd0, exp_q[0][23:8]});
      chk("instr_pc", {24'd0, instr_pc}, {24'd0, exp_q[0][7:0]});
    end else begin
      chk("instr_nop", {16'd0, instr}, {16'd0, NOP_INSTR});
    end
  endtask

  typedef struct {
    logic       stall;
    logic       halt;
    logic       redir;
    logic [7:0] raddr;
    logic       ready;
    logic       exp_req;
    logic [7:0] exp_addr;
    logic       exp_valid;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // stall halt redir raddr ready | req addr valid pc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 8'h01};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 8'h02};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 8'h03};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b1, 8'h03};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b1, 8'h03};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 8'h04};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b1, 8'h40};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b1, 8'h41};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 8'h42, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 1'b1, 8'h20};

    rst_n = 1'b0; stall = 1'b0; halt = 1'b0; redirect_en = 1'b0;
    redirect_addr = 8'h00; imem_ready = 1'b0; imem_rdata = 16'h0000;
    m_pc = RESET_PC; m_halted = 1'b0;

    // reset state
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
    chk("rst_req", {31'd0, act_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'h000F);
    chk("rst_pc", {24'd0, instr_pc}, 32'h00);

    // vector table
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].stall, vecs[i].halt, vecs[i].redir, vecs[i].raddr, vecs[i].ready, 1'b1);
      chk($sformatf("vec%0d_req", i), {31'd0, act_req}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i), {24'd0, act_addr}, {24'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), {24'd0, instr_pc}, {24'd0, vecs[i].exp_pc});
        chk($sformatf("vec%0d_instr", i), {16'd0, instr}, {16'd0, mem_word(vecs[i].exp_pc)});
      end else begin
        chk($sformatf("vec%0d_nop", i), {16'd0, instr}, 32'h000F);
      end
    end

    // stall hold at 05
    step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("stall_req", {31'd0, act_req}, 32'd0);
      chk("stall_pc", {24'd0, instr_pc}, 32'h05);
      chk("stall_instr", {16'd0, instr}, {16'd0, mem_word(8'h05)});
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("stall_release_pc", {24'd0, instr_pc}, 32'h06);

    // wait states at 10
    step(1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("wait_req", {31'd0, act_req}, 32'd1);
      chk("wait_addr", {24'd0, act_addr}, 32'h10);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("wait_capture_pc", {24'd0, instr_pc}, 32'h10);

    // halt with a pending request, then resume by redirect
    step(1'b0, 1'b0, 1'b1, 8'h30, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("halt_pending_req", {31'd0, act_req}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("halt_capture_pc", {24'd0, instr_pc}, 32'h30);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("halted_req", {31'd0, act_req}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("resume_addr", {24'd0, act_addr}, 32'h20);
    chk("resume_pc", {24'd0, instr_pc}, 32'h20);

    // PC wrap
    step(1'b0, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("wrap_fe", {24'd0, instr_pc}, 32'hFE);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("wrap_ff", {24'd0, instr_pc}, 32'hFF);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("wrap_00", {24'd0, instr_pc}, 32'h00);

    // reset in the middle of a request
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("midrst_req", {31'd0, act_req}, 32'd0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_pc", {24'd0, instr_pc}, 32'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("first_fetch_addr", {24'd0, act_addr}, {24'd0, RESET_PC});

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
